moving_averager_mc: RTL

MOVING_AVERAGER_MC -- requirements
Module: moving_averager_mc

---
 rtl/moving_averager_mc.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/moving_averager_mc.sv
// Multi-channel moving-average filter.
// Each channel keeps a circular window of the last WIN samples and a running
// sum. A sample updates its channel's state on the accepting edge, and the
// result is registered onto the outputs on the following edge. Window entries
// that have not yet been written read as zero, so the average ramps up from
// reset or clear instead of dividing by the fill level.
module moving_averager_mc #(
    parameter int DATA_W   = 12,
    parameter int LOG2_WIN = 8,
    parameter int CHANNELS = 4,
    parameter int HR_BITS  = 4,
    parameter int ROUND    = 0,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clr,
    input  logic                      din_valid,
    input  logic [CH_W-1:0]           din_ch,
    input  logic [DATA_W-1:0]         din,
    output logic                      q_valid,
    output logic [CH_W-1:0]           q_ch,
    output logic [DATA_W-1:0]         q,
    output logic [DATA_W+HR_BITS-1:0] q_hr,
    output logic                      q_full
);

    localparam int WIN    = 1 << LOG2_WIN;
    localparam int SUM_W  = DATA_W + LOG2_WIN;
    localparam int FILL_W = LOG2_WIN + 1;
    localparam int HR_W   = DATA_W + HR_BITS;
    localparam int HR_SH  = LOG2_WIN - HR_BITS;

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIN);
    localparam logic [CH_W:0]     CH_LIM   = (CH_W + 1)'(CHANNELS);
    // Half an LSB of the output, added before the divide when rounding.
    localparam logic [SUM_W-1:0]  RND_ADD  =
        (ROUND != 0) ? (SUM_W'(1) << (LOG2_WIN - 1)) : '0;

    // Elaboration-time guard against illegal parameter combinations.
    if (LOG2_WIN < 1 || LOG2_WIN > 10) begin : g_bad_win
        $error("moving_averager_mc: LOG2_WIN must be in 1..10");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_ch
        $error("moving_averager_mc: CHANNELS must be in 1..16");
    end
    if (HR_BITS < 0 || HR_BITS > LOG2_WIN) begin : g_bad_hr
        $error("moving_averager_mc: HR_BITS must be in 0..LOG2_WIN");
    end

    // Per-channel window storage and bookkeeping.
    logic [DATA_W-1:0]   win_mem  [CHANNELS][WIN];
    logic [LOG2_WIN-1:0] wr_ptr   [CHANNELS];
    logic [SUM_W-1:0]    run_sum  [CHANNELS];
    logic [FILL_W-1:0]   fill_cnt [CHANNELS];

    // Accept-path combinational signals.
    logic                ch_ok;
    logic                accept;
    logic [CH_W-1:0]     ch_sel;
    logic [LOG2_WIN-1:0] cur_ptr;
    logic [DATA_W-1:0]   oldest;
    logic [SUM_W-1:0]    sum_new;
    logic [FILL_W-1:0]   fill_new;
    logic                full_new;

    // Result stage between the state update and the output register.
    logic                s_valid;
    logic [CH_W-1:0]     s_ch;
    logic [SUM_W-1:0]    s_sum;
    logic                s_full;
    logic [SUM_W-1:0]    rnd_sum;
    logic [DATA_W-1:0]   q_next;
    logic [HR_W-1:0]     q_hr_next;

    // Decode the incoming sample and form its channel's updated sum and fill.
    // State is written on the same edge the sample is accepted, so a
    // back-to-back sample on the same channel always sees the fresh sum.
    always_comb begin
        ch_ok    = ({1'b0, din_ch} < CH_LIM);
        accept   = din_valid && !clr && ch_ok;
        ch_sel   = ch_ok ? din_ch : '0;
        cur_ptr  = wr_ptr[ch_sel];
        oldest   = win_mem[ch_sel][cur_ptr];
        sum_new  = run_sum[ch_sel]
                   - {{LOG2_WIN{1'b0}}, oldest}
                   + {{LOG2_WIN{1'b0}}, din};
        fill_new = (fill_cnt[ch_sel] == FILL_MAX) ? FILL_MAX
                                                  : fill_cnt[ch_sel] + 1'b1;
        full_new = (fill_new == FILL_MAX);
    end

    // Channel state: window contents, pointers, running sums, fill counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int w = 0; w < WIN; w++) begin
                    win_mem[c][w] <= '0;
                end
                wr_ptr[c]   <= '0;
                run_sum[c]  <= '0;
                fill_cnt[c] <= '0;
            end
        end else if (clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int w = 0; w < WIN; w++) begin
                    win_mem[c][w] <= '0;
                end
                wr_ptr[c]   <= '0;
                run_sum[c]  <= '0;
                fill_cnt[c] <= '0;
            end
        end else if (accept) begin
            win_mem[ch_sel][cur_ptr] <= din;
            wr_ptr[ch_sel]           <= cur_ptr + 1'b1;
            run_sum[ch_sel]          <= sum_new;
            fill_cnt[ch_sel]         <= fill_new;
        end
    end

    // Capture the freshly formed sum so the outputs follow one edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_valid <= 1'b0;
            s_ch    <= '0;
            s_sum   <= '0;
            s_full  <= 1'b0;
        end else begin
            s_valid <= accept;
            if (accept) begin
                s_ch   <= ch_sel;
                s_sum  <= sum_new;
                s_full <= full_new;
            end
        end
    end

    // Divide by the window length; rounding cannot overflow the sum width
    // because the sum never exceeds WIN*(2**DATA_W-1).
    always_comb begin
        rnd_sum   = s_sum + RND_ADD;
        q_next    = DATA_W'(rnd_sum >> LOG2_WIN);
        q_hr_next = HR_W'(s_sum >> HR_SH);
    end

    // Output register; values hold between valid pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_valid <= 1'b0;
            q_ch    <= '0;
            q       <= '0;
            q_hr    <= '0;
            q_full  <= 1'b0;
        end else begin
            q_valid <= s_valid;
            if (s_valid) begin
                q_ch   <= s_ch;
                q      <= q_next;
                q_hr   <= q_hr_next;
                q_full <= s_full;
            end
        end
    end

endmodule
